// File: rtl/zbt_point_writer.sv
// Walks a point-pattern table and writes each entry into ZBT SRAM from BASE_ADDR upward.
// Define ZBT_POINT_WRITER_READBACK_EN to add a verifying read pass that drives `error`.
module zbt_point_writer #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36,
  parameter int IDX_W       = 2,
  parameter int NUM_ENTRIES = 4,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              grant,
  output logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, READ, RDRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t              state_r;
  logic                cnt_r;
  logic [DATA_W-1:0]   d1_r, d2_r;
  logic                v1_r, v2_r;
  logic                start_ok_s;
  logic                issue_s;
  logic [ADDR_W-1:0]   addr_s;

  // A start in the cycle done is still high must not launch a new pass
  assign start_ok_s = (state_r == IDLE) && start && !done;
  assign issue_s    = (state_r == WRITE) && grant;
  assign addr_s     = BASE + {{(ADDR_W-IDX_W){1'b0}}, index};

  // Sequencer: state, index, address/write-enable and busy/done flags
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r  <= IDLE;
      cnt_r    <= 1'b0;
      index    <= {IDX_W{1'b0}};
      mem_addr <= {ADDR_W{1'b0}};
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r <= WRITE;
            index   <= {IDX_W{1'b0}};
            busy    <= 1'b1;
          end
        end
        WRITE: begin
          if (grant) begin
            mem_addr <= addr_s;
            mem_we   <= 1'b1;
            index    <= index + IDX_W'(1);
            if (index == LAST_IDX) begin
              state_r <= DRAIN;
              cnt_r   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (cnt_r) begin
`ifdef ZBT_POINT_WRITER_READBACK_EN
            state_r <= READ;
            index   <= {IDX_W{1'b0}};
`else
            state_r <= DONE;
`endif
            cnt_r   <= 1'b0;
          end else begin
            cnt_r <= 1'b1;
          end
        end
`ifdef ZBT_POINT_WRITER_READBACK_EN
        READ: begin
          if (grant) begin
            mem_addr <= addr_s;
            index    <= index + IDX_W'(1);
            if (index == LAST_IDX) begin
              state_r <= RDRAIN;
              cnt_r   <= 1'b0;
            end
          end
        end
        RDRAIN: begin
          if (cnt_r) begin
            state_r <= DONE;
            cnt_r   <= 1'b0;
          end else begin
            cnt_r <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Write data lags its address by two cycles; the pipe shifts unconditionally
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      d1_r           <= {DATA_W{1'b0}};
      d2_r           <= {DATA_W{1'b0}};
      v1_r           <= 1'b0;
      v2_r           <= 1'b0;
      mem_write_data <= {DATA_W{1'b0}};
    end else begin
      if (issue_s) begin
        d1_r <= value;
      end else begin
        d1_r <= d1_r;
      end
      v1_r <= issue_s;
      d2_r <= d1_r;
      v2_r <= v1_r;
      if (v2_r) begin
        mem_write_data <= d2_r;
      end else begin
        mem_write_data <= mem_write_data;
      end
    end
  end

`ifdef ZBT_POINT_WRITER_READBACK_EN
  logic [DATA_W-1:0] e1_r, e2_r;
  logic              ev1_r, ev2_r;
  logic              rd_issue_s;

  assign rd_issue_s = (state_r == READ) && grant;

  // Expected-data pipe aligned with read latency; error is sticky until next start
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      e1_r  <= {DATA_W{1'b0}};
      e2_r  <= {DATA_W{1'b0}};
      ev1_r <= 1'b0;
      ev2_r <= 1'b0;
      error <= 1'b0;
    end else begin
      e1_r  <= value;
      ev1_r <= rd_issue_s;
      e2_r  <= e1_r;
      ev2_r <= ev1_r;
      if (start_ok_s) begin
        error <= 1'b0;
      end else if (ev2_r && (mem_read_data != e2_r)) begin
        error <= 1'b1;
      end else begin
        error <= error;
      end
    end
  end
`else
  logic unused_rd_s;
  assign unused_rd_s = ^mem_read_data;
  assign error       = 1'b0;
`endif

endmodule

// File: doc/zbt_point_writer.md
# zbt_point_writer

Sequencer that walks a point-pattern table by index and writes each 36-bit entry into ZBT SRAM at consecutive addresses from a base address. It drives the table's `index` input, samples the returned `value`, and issues ZBT write cycles with write data placed two cycles after its address. It shares the ZBT port with other masters through a `grant` input and signals completion with `busy` and `done`. An optional readback pass verifies the written contents.

## Interface

**Parameters**
- `ADDR_W`, 19: ZBT address width.
- `DATA_W`, 36: ZBT data width.
- `IDX_W`, 2: table index width.
- `NUM_ENTRIES`, 4: entries to write; must satisfy 1 ≤ `NUM_ENTRIES` ≤ 2^`IDX_W`.
- `BASE_ADDR`, 0: ZBT address of entry 0.

**Ports**
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a pass; ignored while `busy`.
- `grant` input 1: ZBT port granted to this block this cycle.
- `index` output `IDX_W`: table index, registered.
- `value` input `DATA_W`: table entry for `index`, combinational from the table.
- `mem_addr` output `ADDR_W`: ZBT address, registered.
- `mem_we` output 1: ZBT write enable, active-high, registered.
- `mem_write_data` output `DATA_W`: ZBT write data, registered.
- `mem_read_data` input `DATA_W`: ZBT read data; used only with readback.
- `busy` output 1: a pass is in progress.
- `done` output 1: one-cycle pulse when a pass ends.
- `error` output 1: sticky readback mismatch flag; constant 0 without readback.

## Operation

**States**
- IDLE → WRITE on `start`. On this transition `index` ← 0 and `error` ← 0.
- WRITE: in each cycle with `grant`=1:
  - issue `mem_addr` ← `BASE_ADDR` + `index`, `mem_we` ← 1;
  - capture `value` into data stage 1;
  - increment `index`.
- WRITE with `grant`=0: `mem_we` ← 0; `index` and `mem_addr` hold.
- After entry `NUM_ENTRIES`−1 is issued, WRITE → DRAIN.
- DRAIN lasts 2 cycles, independent of `grant`, so the last write data leaves.
- DRAIN exits to DONE, or to READ when readback is compiled in.
- DONE lasts 1 cycle with `done`=1, then → IDLE.

**Data pipeline**
- Two-stage shift register with a valid bit per stage. It shifts every cycle, regardless of `grant` or state.
- `mem_write_data` ← stage 2 when stage 2 is valid; otherwise it holds its last value.

**Other rules**
- `busy`=1 in every state except IDLE. It deasserts in the same cycle `done` rises and clears.
- Address arithmetic: `BASE_ADDR` + `index`, zero-extended, modulo 2^`ADDR_W`. Wrap past the top address is allowed and silent.
- `start` while `busy`=1 has no effect.
- `start` in the same cycle `done` is high is ignored. A new pass needs `start` while in IDLE.
- Reset mid-pass aborts immediately. Writes still in flight are lost; the data stage valid bits clear.

**Reset values (`reset_b`=0)**
- `index`, `mem_addr`, `mem_write_data` = 0.
- `mem_we`, `busy`, `done`, `error` = 0.
- state = IDLE.

## Timing

- `start` sampled at edge 0 → `busy`=1 and `index`=0 after edge 0.
- Write issue for entry i: `grant`=1 sampled at edge k.
  - after edge k: `mem_addr` = `BASE_ADDR`+i, `mem_we`=1;
  - after edge k+2: `mem_write_data` = value(i).
- Full-grant pass: writes occupy `NUM_ENTRIES` consecutive cycles, then 2 DRAIN cycles, then 1 DONE cycle.
  - Total from `start` edge to `done` high = `NUM_ENTRIES`+3 cycles; 7 for the defaults.
- Each `grant`=0 cycle during WRITE adds exactly one cycle.

## Configuration

Macro: `ZBT_POINT_WRITER_READBACK_EN`.

**Defined:**
- After DRAIN, `index` ← 0 and the block enters READ.
- READ: in each `grant`=1 cycle, issue `mem_addr` = `BASE_ADDR`+`index` with `mem_we`=0. `value` enters an expected-data pipe of 2 stages.
- Two cycles after each read address, `mem_read_data` is compared to the expected value. Any mismatch sets `error`, which stays set until the next `start`.
- After the last read, RDRAIN lasts 2 cycles to finish the compares, then → DONE.
- Full-grant total = 2·`NUM_ENTRIES`+5 cycles.

**Undefined:**
- There is no READ or RDRAIN state; DRAIN goes directly to DONE.
- `error` is tied to 0 and `mem_read_data` is unused.

## Test plan

- Reset, then `start` with `grant`=1 and bench table 0x12C4B/0x19064/0x1F47D/0x25896.
  - Required: `mem_we`=1 on addrs 0,1,2,3 in consecutive cycles.
  - Required: `mem_write_data` shows the same values 2 cycles later.
  - Required: `done` 7 cycles after `start`.
- `grant`=0 for 3 cycles after the second write.
  - Required: `mem_we`=0 and addr/index held during the gap.
  - Required: data for addr 1 still appears on time; `done` at cycle 10.
- `BASE_ADDR`=2^19−2.
  - Required: writes go to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- `start` pulsed mid-pass and again in the `done` cycle.
  - Required: no restart; exactly 4 writes; `busy` falls with `done`.
- `reset_b` low during WRITE after 2 writes.
  - Required: all outputs 0 immediately; no further `mem_we` or `mem_write_data` change until the next `start`.
- Readback build, bench memory model corrupting addr 2.
  - Required: `error`=1 at `done` (13 cycles after `start`); a clean rerun after a new `start` leaves `error`=0.
